// File: rtl/alarm_beeper.sv
// Purpose : alarm sounder; gated square-wave tone in timed beep/gap bursts, with snooze, stop and auto-timeout.
// Latency : one clk from an input tick to the matching state/output change; all outputs are registers.
// Backpress: none; trigger/stop/snooze are sampled every cycle (a held level counts as one event per cycle).
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   trigger  - start tick (honoured only in IDLE)
//   stop     - stop tick (returns to IDLE from any active state, no done pulse)
//   snooze   - snooze tick (honoured in BEEP and GAP)
//   buzzer   - square-wave tone drive, only toggles during BEEP
//   led      - high during BEEP
//   active   - high whenever the sequencer is not IDLE
//   snoozing - high during SNOOZE
//   done     - one-cycle pulse on the first IDLE cycle after the last gap
module alarm_beeper #(
    parameter int unsigned TONE_DIV     = 25000,
    parameter int unsigned BEEP_ON_CYC  = 25000000,
    parameter int unsigned BEEP_OFF_CYC = 25000000,
    parameter int unsigned MAX_BEEPS    = 60,
    parameter int unsigned SNOOZE_CYC   = 500000000
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    input  logic stop,
    input  logic snooze,
    output logic buzzer,
    output logic led,
    output logic active,
    output logic snoozing,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BEEP   = 2'd1,
        ST_GAP    = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    // Terminal counts: a counter that starts at 0 on state entry and leaves
    // the state when it reaches N-1 gives exactly N cycles in that state.
    localparam logic [31:0] TONE_LAST   = 32'(TONE_DIV - 1);
    localparam logic [31:0] BEEP_LAST   = 32'(BEEP_ON_CYC - 1);
    localparam logic [31:0] GAP_LAST    = 32'(BEEP_OFF_CYC - 1);
    localparam logic [31:0] SNOOZE_LAST = 32'(SNOOZE_CYC - 1);
    localparam logic [15:0] BEEP_MAX    = 16'(MAX_BEEPS);

    state_t      state;
    logic [31:0] dur_cnt;
    logic [31:0] tone_cnt;
    logic [15:0] beep_cnt;
    logic [15:0] beep_inc;

    assign beep_inc = beep_cnt + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            beep_cnt <= '0;
            buzzer   <= 1'b0;
            led      <= 1'b0;
            active   <= 1'b0;
            snoozing <= 1'b0;
            done     <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the timeout branch raises it.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state    <= ST_BEEP;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        beep_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b1;
                        active   <= 1'b1;
                        snoozing <= 1'b0;
                    end
                end

                ST_BEEP: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        beep_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b0;
                        active   <= 1'b0;
                        snoozing <= 1'b0;
                    end else if (snooze) begin
                        state    <= ST_SNOOZE;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b0;
                        snoozing <= 1'b1;
                    end else if (dur_cnt == BEEP_LAST) begin
                        state    <= ST_GAP;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b0;
                    end else begin
                        dur_cnt <= dur_cnt + 32'd1;
                        // Buzzer entered BEEP low, so the first rising edge
                        // lands TONE_DIV cycles after entry.
                        if (tone_cnt == TONE_LAST) begin
                            tone_cnt <= '0;
                            buzzer   <= ~buzzer;
                        end else begin
                            tone_cnt <= tone_cnt + 32'd1;
                        end
                    end
                end

                ST_GAP: begin
                    if (stop) begin
                        state    <= ST_IDLE;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        beep_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b0;
                        active   <= 1'b0;
                        snoozing <= 1'b0;
                    end else if (snooze) begin
                        state    <= ST_SNOOZE;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b0;
                        snoozing <= 1'b1;
                    end else if (dur_cnt == GAP_LAST) begin
                        // A beep period is counted only once its gap completes.
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        buzzer   <= 1'b0;
                        if (beep_inc == BEEP_MAX) begin
                            state    <= ST_IDLE;
                            beep_cnt <= '0;
                            led      <= 1'b0;
                            active   <= 1'b0;
                            snoozing <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= ST_BEEP;
                            beep_cnt <= beep_inc;
                            led      <= 1'b1;
                        end
                    end else begin
                        dur_cnt <= dur_cnt + 32'd1;
                    end
                end

                ST_SNOOZE: begin
                    // snooze is deliberately ignored here: a repeat press does
                    // not extend the snooze window.
                    if (stop) begin
                        state    <= ST_IDLE;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        beep_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b0;
                        active   <= 1'b0;
                        snoozing <= 1'b0;
                    end else if (dur_cnt == SNOOZE_LAST) begin
                        // Waking from snooze grants a fresh full set of beeps.
                        state    <= ST_BEEP;
                        dur_cnt  <= '0;
                        tone_cnt <= '0;
                        beep_cnt <= '0;
                        buzzer   <= 1'b0;
                        led      <= 1'b1;
                        snoozing <= 1'b0;
                    end else begin
                        dur_cnt <= dur_cnt + 32'd1;
                    end
                end

                default: begin
                    // Recovery path for a corrupted state register.
                    state    <= ST_IDLE;
                    dur_cnt  <= '0;
                    tone_cnt <= '0;
                    beep_cnt <= '0;
                    buzzer   <= 1'b0;
                    led      <= 1'b0;
                    active   <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule
